// File: rtl/ext_unit_pipe.sv
// rtl/ext_unit_pipe.sv - pipelined immediate-extension unit with a 2-entry skid buffer
// Extension is resolved at acceptance so the stored entry is already the final operand.
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] sext_data;
  logic [OUT_W-1:0] ext_data;

  logic             main_valid;
  logic [OUT_W-1:0] main_data;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;

  logic accept;
  logic main_free;

  assign sext_data = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

  always_comb begin
    ext_data = sext_data;
    case (in_op)
      2'b00:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_data};
      2'b01:   ext_data = sext_data;
      2'b10:   ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
      default: ext_data = sext_data << 2;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      // Data registers keep their last value; only occupancy is dropped.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= ext_data;
        main_tag   <= in_tag;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // in_ready was high, so the skid is empty and can take the stalled-side entry.
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_tag   <= in_tag;
    end
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

endmodule
